// File: rtl/mux_arb_n_pkg.sv
// mux_pkg: shared mode encodings and channel-slice helper
// for the N-channel operand selector (mux_arb_n).
package mux_pkg;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_RR     = 1'b1;

   // LSB position of channel k in a flat bus of w-bit slices
   function automatic int ch_lsb(input int k, input int w);
      return k * w;
   endfunction

endpackage

// File: rtl/mux_arb_n_rr_pick.sv
// rr_pick_n: combinational round-robin picker.
// Ports: valid (per-channel), rr_ptr (last grant) -> grant_idx, grant_any.
module rr_pick_n #(
   parameter  int N_CH  = 4,
   localparam int SEL_W = $clog2(N_CH)
) (
   input  logic [N_CH-1:0]  valid,
   input  logic [SEL_W-1:0] rr_ptr,
   output logic [SEL_W-1:0] grant_idx,
   output logic             grant_any
);

   int c;

   // Scan from farthest to nearest so the channel right after
   // rr_ptr is the last writer and therefore wins.
   always_comb begin
      grant_idx = '0;
      grant_any = 1'b0;
      c         = 0;
      for (int i = N_CH; i >= 1; i--) begin
         c = (int'(rr_ptr) + i) % N_CH;
         if (valid[c]) begin
            grant_idx = SEL_W'(c);
            grant_any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_arb_n.sv
// mux_arb_n: N-channel registered selector, direct or round-robin.
// Ports: mux_in_data/valid/ready (per channel), mux_sel, mux_mode,
//        mux_out/_valid/_ready/_ch (registered output stage).
module mux_arb_n #(
   parameter  int WIDTH = 4,
   parameter  int N_CH  = 4,
   localparam int SEL_W = $clog2(N_CH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_CH*WIDTH-1:0] mux_in_data,
   input  logic [N_CH-1:0]       mux_in_valid,
   output logic [N_CH-1:0]       mux_in_ready,
   input  logic [SEL_W-1:0]      mux_sel,
   input  logic                  mux_mode,
   output logic [WIDTH-1:0]      mux_out,
   output logic                  mux_out_valid,
   input  logic                  mux_out_ready,
   output logic [SEL_W-1:0]      mux_out_ch
);

   import mux_pkg::*;

   logic [WIDTH-1:0] ch_data [N_CH];
   logic [SEL_W-1:0] rr_ptr;
   logic [SEL_W-1:0] rr_idx;
   logic [SEL_W-1:0] grant;
   logic             rr_any;
   logic             sel_ok;
   logic             dir_any;
   logic             gnt_any;
   logic             load_en;
   logic             xfer;

   always_comb begin
      for (int k = 0; k < N_CH; k++) begin
         ch_data[k] = mux_in_data[ch_lsb(k, WIDTH) +: WIDTH];
      end
   end

   rr_pick_n #(
      .N_CH (N_CH)
   ) u_pick (
      .valid     (mux_in_valid),
      .rr_ptr    (rr_ptr),
      .grant_idx (rr_idx),
      .grant_any (rr_any)
   );

   // Non-power-of-two N_CH leaves select codes with no channel
   assign sel_ok  = {1'b0, mux_sel} < (SEL_W+1)'(N_CH);
   assign dir_any = sel_ok & mux_in_valid[mux_sel];

   always_comb begin
      grant   = mux_sel;
      gnt_any = dir_any;
      if (mux_mode == MODE_RR) begin
         grant   = rr_idx;
         gnt_any = rr_any;
      end
   end

   assign load_en = !mux_out_valid | mux_out_ready;
   assign xfer    = load_en & gnt_any;

   always_comb begin
      mux_in_ready = '0;
      if (xfer) begin
         mux_in_ready[grant] = 1'b1;
      end
   end

   // rr_ptr only moves on RR transfers so direct-mode traffic
   // does not disturb fairness when switching back.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mux_out       <= '0;
         mux_out_valid <= 1'b0;
         mux_out_ch    <= '0;
         rr_ptr        <= SEL_W'(N_CH - 1);
      end else begin
         if (xfer) begin
            mux_out       <= ch_data[grant];
            mux_out_ch    <= grant;
            mux_out_valid <= 1'b1;
            if (mux_mode == MODE_RR) begin
               rr_ptr <= grant;
            end
         end else if (mux_out_ready) begin
            mux_out_valid <= 1'b0;
         end
      end
   end

endmodule
